filter_sp_stream_ctrl: RTL and testbench

Sequential successor to the combinational filter read controller. It owns the filter scratchpad's write and read pointers and treats the usable depth as a circular buffer of whole filters. Each filter can be read REUSE times before its slot is released, and a job streams a programmable number of filters. It sits between the filter input buffer and the filter scratchpad / PE read port.

---
 rtl/filter_sp_pkg.sv | 21 ++
 rtl/sp_wrap_counter.sv | 34 +++
 rtl/filter_sp_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_filter_sp_stream_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sp_pkg.sv
// Shared types and helpers for the filter scratchpad stream controller.
// Holds the FSM encoding, occupancy width extension and the usable-depth helper.
package filter_sp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sp_state_t;

    // occupancy and address sums need one bit above the pointer width
    localparam int OCC_EXTRA_BITS = 1;

    // Largest multiple of fs that fits in sp_size: the circular buffer only ever holds whole filters.
    function automatic int calc_limit(input int sp_size, input int fs);
        if (fs <= 0) begin
            return sp_size;
        end
        return sp_size - (sp_size % fs);
    endfunction

endpackage

// File: rtl/sp_wrap_counter.sv
// Modulo-limit pointer: advances by step when enabled, wrapping at limit; load clears to zero.
// Latency: count updates on the clock after en/load; load wins over en.
module sp_wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] step,
    input  logic [W:0]   limit,
    output logic [W-1:0] count
);

    logic [W:0]   sum;
    logic [W-1:0] wrapped;

    // count < limit and step <= limit, so one conditional subtract is enough
    always_comb begin
        sum     = {1'b0, count} + {1'b0, step};
        wrapped = W'((sum >= limit) ? (sum - limit) : sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= wrapped;
        end
    end

endmodule

// File: rtl/filter_sp_stream_ctrl.sv
// Filter scratchpad controller: circular buffer of whole filters, each read reuse_count times.
// Reads may trail writes within a filter; writes stall on full occupancy or when the job is fully loaded.
module filter_sp_stream_ctrl
    import filter_sp_pkg::*;
#(
    parameter int SP_SIZE              = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int POINTER_SIZE         = 8,
    parameter int COUNT_SIZE           = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    input  logic [COUNT_SIZE-1:0]           reuse_count,
    input  logic [COUNT_SIZE-1:0]           num_filters,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            sp_wr_en,
    output logic [POINTER_SIZE-1:0]         sp_wr_addr,
    input  logic                            rd_en,
    output logic                            av_filter,
    output logic [POINTER_SIZE-1:0]         sp_rd_addr,
    output logic                            end_of_filter,
    output logic                            done,
    output logic                            busy,
    output logic                            cfg_err
);

    localparam int PW = POINTER_SIZE;
    localparam int OW = POINTER_SIZE + OCC_EXTRA_BITS;
    localparam int FW = FILTER_SIZE_REG_SIZE;
    localparam int CW = COUNT_SIZE;
    // written spans the whole job, so it is sized for N*FS rather than the scratchpad
    localparam int WW = COUNT_SIZE + FILTER_SIZE_REG_SIZE;

    sp_state_t     state, state_nxt;
    logic [FW-1:0] fs_q, off;
    logic [OW-1:0] limit_q, occ, rd_sum;
    logic [CW-1:0] r_q, n_q, pass, fcnt;
    logic [WW-1:0] written, total;
    logic [PW-1:0] base;
    logic          active, cfg_ok, accept, rd_fire, last_word, release_slot, ptr_clr;

    assign active = (state == ACTIVE);
    assign busy   = active;
    assign cfg_ok = (filter_size != '0) && (int'(filter_size) <= SP_SIZE)
                 && (reuse_count != '0) && (num_filters != '0);
    assign accept = start && !active && cfg_ok;
    assign total  = WW'(n_q) * WW'(fs_q);

    assign in_ready      = active && (occ < limit_q) && (written < total);
    assign sp_wr_en      = in_valid && in_ready;
    assign av_filter     = active && (occ > OW'(off));
    assign rd_fire       = rd_en && av_filter;
    assign last_word     = (off == fs_q - FW'(1));
    assign end_of_filter = rd_fire && last_word;
    assign release_slot  = end_of_filter && (pass == r_q - CW'(1));
    assign done          = release_slot && (fcnt == n_q - CW'(1));
    assign ptr_clr       = accept || done;

    always_comb begin
        rd_sum     = {1'b0, base} + OW'(off);
        sp_rd_addr = PW'((rd_sum >= limit_q) ? (rd_sum - limit_q) : rd_sum);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACTIVE;
            ACTIVE:  if (done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
            fs_q    <= '0;
            limit_q <= '0;
            r_q     <= '0;
            n_q     <= '0;
            occ     <= '0;
            written <= '0;
            off     <= '0;
            pass    <= '0;
            fcnt    <= '0;
        end else begin
            state   <= state_nxt;
            cfg_err <= start && !active && !cfg_ok;
            if (accept) begin
                fs_q    <= filter_size;
                limit_q <= OW'(calc_limit(SP_SIZE, int'(filter_size)));
                r_q     <= reuse_count;
                n_q     <= num_filters;
                occ     <= '0;
                written <= '0;
                off     <= '0;
                pass    <= '0;
                fcnt    <= '0;
            end else if (active) begin
                occ <= occ + OW'(sp_wr_en) - (release_slot ? OW'(fs_q) : '0);
                if (sp_wr_en) begin
                    written <= written + WW'(1);
                end
                if (rd_fire) begin
                    if (last_word) begin
                        off <= '0;
                        if (release_slot) begin
                            pass <= '0;
                            fcnt <= fcnt + CW'(1);
                        end else begin
                            pass <= pass + CW'(1);
                        end
                    end else begin
                        off <= off + FW'(1);
                    end
                end
            end
        end
    end

    sp_wrap_counter #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ptr_clr),
        .en    (sp_wr_en),
        .step  (PW'(1)),
        .limit (limit_q),
        .count (sp_wr_addr)
    );

    sp_wrap_counter #(.W(PW)) u_base (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ptr_clr),
        .en    (release_slot),
        .step  (PW'(fs_q)),
        .limit (limit_q),
        .count (base)
    );

endmodule

// File: tb/tb_filter_sp_stream_ctrl.sv
// Directed bench for filter_sp_stream_ctrl: reset, streaming, reuse, wrap, underrun and config rejection.
module tb_filter_sp_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, rd_en;
    logic [7:0] filter_size, reuse_count, num_filters;
    logic       in_ready, sp_wr_en, av_filter, end_of_filter, done, busy, cfg_err;
    logic [7:0] sp_wr_addr, sp_rd_addr;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    filter_sp_stream_ctrl #(
        .SP_SIZE(8), .FILTER_SIZE_REG_SIZE(8), .POINTER_SIZE(8), .COUNT_SIZE(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .filter_size(filter_size),
        .reuse_count(reuse_count), .num_filters(num_filters), .in_valid(in_valid),
        .in_ready(in_ready), .sp_wr_en(sp_wr_en), .sp_wr_addr(sp_wr_addr), .rd_en(rd_en),
        .av_filter(av_filter), .sp_rd_addr(sp_rd_addr), .end_of_filter(end_of_filter),
        .done(done), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int fs, input int r, input int n);
        filter_size = 8'(fs);
        reuse_count = 8'(r);
        num_filters = 8'(n);
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        filter_size = '0; reuse_count = '0; num_filters = '0;
        step(); step();
        checks++;
        if ({busy, in_ready, av_filter, end_of_filter, done, cfg_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, in_ready, av_filter, end_of_filter, done, cfg_err});
        end
        rst_n = 1'b1;
        step();
        launch(3, 1, 2);
        in_valid = 1'b1; rd_en = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy, in_ready, sp_wr_en, av_filter, end_of_filter, done, cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 0000000",
                     {busy, in_ready, sp_wr_en, av_filter, end_of_filter, done, cfg_err});
        end
        checks++;
        if (sp_wr_addr !== 8'd0 || sp_rd_addr !== 8'd0) begin
            errors++;
            $display("FAIL midreset_addr: got wr=%0d rd=%0d expected 0 0", sp_wr_addr, sp_rd_addr);
        end
        rst_n = 1'b1; in_valid = 1'b0; rd_en = 1'b0;
        step();
    endtask

    task automatic test_stream();
        launch(3, 1, 2);
        in_valid = 1'b1; rd_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (in_ready !== (k < 6)) begin
                errors++;
                $display("FAIL stream_in_ready[%0d]: got %b expected %b", k, in_ready, (k < 6));
            end
            if (k < 6) begin
                checks++;
                if (sp_wr_addr !== 8'(k)) begin
                    errors++;
                    $display("FAIL stream_wr_addr[%0d]: got %0d expected %0d", k, sp_wr_addr, k);
                end
            end
            step();
        end
        in_valid = 1'b0; rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if ({av_filter, sp_rd_addr, end_of_filter, done} !== {1'b1, 8'(k), (k == 2 || k == 5), (k == 5)}) begin
                errors++;
                $display("FAIL stream_rd[%0d]: got av=%b addr=%0d eof=%b done=%b expected av=1 addr=%0d eof=%b done=%b",
                         k, av_filter, sp_rd_addr, end_of_filter, done, k, (k == 2 || k == 5), (k == 5));
            end
            step();
        end
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_reuse();
        int exp_addr[6] = '{0, 1, 2, 0, 1, 2};
        launch(3, 2, 1);
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0; rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if ({av_filter, sp_rd_addr, end_of_filter, done} !== {1'b1, 8'(exp_addr[k]), (k == 2 || k == 5), (k == 5)}) begin
                errors++;
                $display("FAIL reuse_rd[%0d]: got av=%b addr=%0d eof=%b done=%b expected av=1 addr=%0d eof=%b done=%b",
                         k, av_filter, sp_rd_addr, end_of_filter, done, exp_addr[k], (k == 2 || k == 5), (k == 5));
            end
            step();
        end
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reuse_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_wrap();
        int   exp_rd[9]    = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
        logic exp_rdy[9]   = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        int   exp_wr[9]    = '{0, 0, 0, 0, 1, 2, 0, 0, 0};
        launch(3, 1, 3);
        in_valid = 1'b1; rd_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            checks++;
            if (in_ready !== (k < 6)) begin
                errors++;
                $display("FAIL wrap_fill_ready[%0d]: got %b expected %b", k, in_ready, (k < 6));
            end
            step();
        end
        rd_en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            #1;
            checks++;
            if ({av_filter, sp_rd_addr, in_ready, end_of_filter, done} !==
                {1'b1, 8'(exp_rd[j]), exp_rdy[j], (j % 3 == 2), (j == 8)}) begin
                errors++;
                $display("FAIL wrap_cycle[%0d]: got av=%b rd=%0d rdy=%b eof=%b done=%b expected av=1 rd=%0d rdy=%b eof=%b done=%b",
                         j, av_filter, sp_rd_addr, in_ready, end_of_filter, done,
                         exp_rd[j], exp_rdy[j], (j % 3 == 2), (j == 8));
            end
            if (exp_rdy[j]) begin
                checks++;
                if (sp_wr_addr !== 8'(exp_wr[j])) begin
                    errors++;
                    $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", j, sp_wr_addr, exp_wr[j]);
                end
            end
            step();
        end
        in_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_underrun();
        launch(4, 1, 1);
        rd_en = 1'b1;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c % 3 == 0);
            #1;
            checks++;
            if ({av_filter, end_of_filter, done} !== {(c % 3 == 1), (c == 10), (c == 10)}) begin
                errors++;
                $display("FAIL underrun_flags[%0d]: got av=%b eof=%b done=%b expected av=%b eof=%b done=%b",
                         c, av_filter, end_of_filter, done, (c % 3 == 1), (c == 10), (c == 10));
            end
            if (c % 3 == 1) begin
                checks++;
                if (sp_rd_addr !== 8'(c / 3)) begin
                    errors++;
                    $display("FAIL underrun_rd_addr[%0d]: got %0d expected %0d", c, sp_rd_addr, c / 3);
                end
            end
            if (c % 3 == 0) begin
                checks++;
                if (in_ready !== 1'b1 || sp_wr_addr !== 8'(c / 3)) begin
                    errors++;
                    $display("FAIL underrun_wr[%0d]: got rdy=%b addr=%0d expected rdy=1 addr=%0d",
                             c, in_ready, sp_wr_addr, c / 3);
                end
            end
            step();
        end
        in_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL underrun_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_config();
        int fs_tab[3] = '{0, 9, 3};
        int r_tab[3]  = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            launch(fs_tab[i], r_tab[i], 1);
            checks++;
            if ({cfg_err, busy} !== 2'b10) begin
                errors++;
                $display("FAIL config_reject[%0d]: got cfg_err=%b busy=%b expected 1 0", i, cfg_err, busy);
            end
            step();
            checks++;
            if ({cfg_err, busy} !== 2'b00) begin
                errors++;
                $display("FAIL config_pulse_end[%0d]: got cfg_err=%b busy=%b expected 0 0", i, cfg_err, busy);
            end
        end
        launch(8, 1, 1);
        checks++;
        if ({cfg_err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL config_accept_fs8: got cfg_err=%b busy=%b expected 0 1", cfg_err, busy);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reuse();
        test_wrap();
        test_underrun();
        test_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
